// File: rtl/decode_stage.sv
// Registered RV32I decode stage with valid/ready handshake on both sides.
// Optional DECODE_SKID_EN adds a one-entry skid register so in_ready becomes a flop output.
module decode_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic            out_rs1_en,
  output logic            out_rs2_en,
  output logic            out_rd_en
);

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_t;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
    logic            rs1_en;
    logic            rs2_en;
    logic            rd_en;
  } bundle_t;

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [6:0]         funct7;
  fmt_t               fmt;
  logic signed [31:0] imm32;
  bundle_t            dec;
  bundle_t            out_q;
  logic               out_valid_q;
  logic               in_fire;
  logic               out_fire;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  // Every legal opcode ends in 2'b11, so the default arm also catches instr[1:0] != 2'b11.
  always_comb begin
    fmt = FMT_ILL;
    case (opcode)
      7'b0110111, 7'b0010111: fmt = FMT_U;
      7'b1101111:             fmt = FMT_J;
      7'b1100111:             fmt = (funct3 == 3'd0) ? FMT_I : FMT_ILL;
      7'b1100011:             fmt = (funct3 == 3'd2 || funct3 == 3'd3) ? FMT_ILL : FMT_B;
      7'b0000011:             fmt = (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7) ? FMT_ILL : FMT_I;
      7'b0100011:             fmt = (funct3 <= 3'd2) ? FMT_S : FMT_ILL;
      7'b0010011: begin
        if (funct3 == 3'd1)
          fmt = (funct7 == 7'b0000000) ? FMT_I : FMT_ILL;
        else if (funct3 == 3'd5)
          fmt = (funct7 == 7'b0000000 || funct7 == 7'b0100000) ? FMT_I : FMT_ILL;
        else
          fmt = FMT_I;
      end
      7'b0110011: begin
        if (funct7 == 7'b0000000)
          fmt = FMT_R;
        else if (funct7 == 7'b0100000 && (funct3 == 3'd0 || funct3 == 3'd5))
          fmt = FMT_R;
        else
          fmt = FMT_ILL;
      end
      7'b0001111, 7'b1110011: fmt = FMT_I;
      default:                fmt = FMT_ILL;
    endcase
  end

  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I:   imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      FMT_S:   imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      FMT_B:   imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                        in_instr[11:8], 1'b0};
      FMT_U:   imm32 = {in_instr[31:12], 12'b0};
      FMT_J:   imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                        in_instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  always_comb begin
    dec         = '0;
    dec.pc      = in_pc;
    dec.opcode  = opcode;
    dec.funct3  = funct3;
    dec.funct7  = funct7;
    dec.rs1     = in_instr[19:15];
    dec.rs2     = in_instr[24:20];
    dec.rd      = in_instr[11:7];
    dec.imm     = XLEN'(imm32);
    dec.fmt     = fmt;
    dec.illegal = (fmt == FMT_ILL);
    dec.rs1_en  = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_B);
    dec.rs2_en  = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);
    dec.rd_en   = ((fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_U) || (fmt == FMT_J))
                  && (in_instr[11:7] != 5'd0);
  end

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

`ifdef DECODE_SKID_EN
  bundle_t skid_q;
  logic    skid_valid_q;

  assign in_ready = !skid_valid_q;

  // A free output slot drains the skid entry first; otherwise a stalled accept parks in the skid.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (in_fire) begin
        out_q       <= dec;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (in_fire) begin
      skid_q       <= dec;
      skid_valid_q <= 1'b1;
    end
  end
`else
  assign in_ready = !out_valid_q || out_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (in_fire) begin
      out_q       <= dec;
      out_valid_q <= 1'b1;
    end else if (out_fire) begin
      out_valid_q <= 1'b0;
    end
  end
`endif

  assign out_valid   = out_valid_q;
  assign out_pc      = out_q.pc;
  assign out_opcode  = out_q.opcode;
  assign out_funct3  = out_q.funct3;
  assign out_funct7  = out_q.funct7;
  assign out_rs1     = out_q.rs1;
  assign out_rs2     = out_q.rs2;
  assign out_rd      = out_q.rd;
  assign out_imm     = out_q.imm;
  assign out_fmt     = out_q.fmt;
  assign out_illegal = out_q.illegal;
  assign out_rs1_en  = out_q.rs1_en;
  assign out_rs2_en  = out_q.rs2_en;
  assign out_rd_en   = out_q.rd_en;

endmodule
